// File: rtl/uart_arm_cmd.sv
// UART (8N1) command receiver for the three-servo arm: decodes single ASCII
// characters into retriggerable hold-to-move levels key1..key6 and sg90_en.
module uart_arm_cmd #(
  parameter int   CLKS_PER_BIT = 5208,
  parameter int   HOLD_CYCLES  = 5_000_000,
  parameter logic EN_RESET     = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic       key1,
  output logic       key2,
  output logic       key3,
  output logic       key4,
  output logic       key5,
  output logic       key6,
  output logic       sg90_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [23:0]    HOLD_LOAD = 24'(HOLD_CYCLES);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_arm_cmd: CLKS_PER_BIT must be at least 4");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 24'hFF_FFFF) begin : g_bad_hold
    $error("uart_arm_cmd: HOLD_CYCLES must be in 1 .. 2^24-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;

  rx_state_t     state, state_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic          fall_edge;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          tick, shift_en, stop_ok, stop_bad;

  logic [5:0]    keys, keys_next;
  logic [23:0]   hold_cnt, hold_next;
  logic          en_next;

  // ---------------------------------------------------------------------------
  // Synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the chain resets low so a line held low across reset
  // release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Receiver FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (fall_edge) state_next = S_START;
      S_START: if (bit_cnt == HALF_LAST) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (bit_cnt == BIT_LAST && bit_idx == 3'd7) state_next = S_STOP;
      S_STOP:  if (bit_cnt == BIT_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tick     = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state)
      S_START: tick = (bit_cnt == HALF_LAST);
      S_DATA: begin
        tick     = (bit_cnt == BIT_LAST);
        shift_en = tick;
      end
      S_STOP: begin
        tick     = (bit_cnt == BIT_LAST);
        stop_ok  = tick & rx_sync;
        stop_bad = tick & ~rx_sync;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver datapath
  // ---------------------------------------------------------------------------
  // The bit counter restarts at every sample point so each stage measures its
  // own interval from the previous sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state == S_IDLE || tick) bit_cnt <= '0;
      else                         bit_cnt <= bit_cnt + 1'b1;

      if (state != S_DATA) bit_idx <= 3'd0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) rx_data <= shift_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode and hold timer
  // ---------------------------------------------------------------------------
  // Expiry is evaluated first so that a byte decoded in the same cycle
  // overrides it; bytes without an effect leave the running hold untouched.
  always_comb begin
    keys_next = keys;
    hold_next = hold_cnt;
    en_next   = sg90_en;

    if (hold_cnt != 24'd0) begin
      hold_next = hold_cnt - 24'd1;
      if (hold_cnt == 24'd1) keys_next = 6'b000000;
    end

    if (rx_valid) begin
      unique case (rx_data)
        8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36: begin
          if (sg90_en) begin
            keys_next = 6'b000001 << (rx_data[2:0] - 3'd1);
            hold_next = HOLD_LOAD;
          end
        end
        8'h53: begin
          keys_next = 6'b000000;
          hold_next = 24'd0;
        end
        8'h45: en_next = 1'b1;
        8'h58: begin
          en_next   = 1'b0;
          keys_next = 6'b000000;
          hold_next = 24'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      keys     <= 6'b000000;
      hold_cnt <= 24'd0;
      sg90_en  <= EN_RESET;
    end else begin
      keys     <= keys_next;
      hold_cnt <= hold_next;
      sg90_en  <= en_next;
    end
  end

  assign key1 = keys[0];
  assign key2 = keys[1];
  assign key3 = keys[2];
  assign key4 = keys[3];
  assign key5 = keys[4];
  assign key6 = keys[5];

endmodule

// File: tb/tb_uart_arm_cmd.sv
// Self-checking bench for uart_arm_cmd: table of single-frame commands plus
// hand-written sequences for hold timing, back-to-back frames, glitches and reset.
module tb_uart_arm_cmd;

  localparam int CPB  = 16;
  localparam int HOLD = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_rx;
  logic       key1, key2, key3, key4, key5, key6;
  logic       sg90_en, rx_valid, frame_err;
  logic [7:0] rx_data;

  uart_arm_cmd #(
    .CLKS_PER_BIT(CPB),
    .HOLD_CYCLES (HOLD),
    .EN_RESET    (1'b1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_rx  (uart_rx),
    .key1     (key1),
    .key2     (key2),
    .key3     (key3),
    .key4     (key4),
    .key5     (key5),
    .key6     (key6),
    .sg90_en  (sg90_en),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor, sampled on the falling clock edge
  // ---------------------------------------------------------------------------
  logic [5:0] keys;
  assign keys = {key6, key5, key4, key3, key2, key1};

  int         cyc       = 0;
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         valid_cyc = 0;
  int         multi_hot = 0;
  logic [7:0] last_data = 8'h00;
  logic       snap_pend = 1'b0;
  logic [5:0] keys_snap = '0;
  logic       en_snap   = 1'b0;
  logic [5:0] keys_prev = '0;
  int         run[6]      = '{default: 0};
  int         last_run[6] = '{default: 0};
  int         rise_cnt[6] = '{default: 0};
  int         rise_cyc[6] = '{default: 0};
  int         fall_cyc[6] = '{default: 0};

  always @(negedge sys_clk) begin
    cyc++;
    if (snap_pend) begin
      keys_snap = keys;
      en_snap   = sg90_en;
      snap_pend = 1'b0;
    end
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      last_data = rx_data;
      snap_pend = 1'b1;
    end
    if (frame_err) ferr_cnt++;
    if ($countones(keys) > 1) multi_hot++;
    for (int i = 0; i < 6; i++) begin
      if (keys[i]) begin
        run[i]++;
        if (!keys_prev[i]) begin
          rise_cnt[i]++;
          rise_cyc[i] = cyc;
        end
      end else if (keys_prev[i]) begin
        last_run[i] = run[i];
        run[i]      = 0;
        fall_cyc[i] = cyc;
      end
    end
    keys_prev = keys;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int tail_low);
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int b = 0; b < 8; b++) begin
      uart_rx = d[b];
      wait_cycles(CPB);
    end
    uart_rx = stop;
    wait_cycles(CPB);
    if (tail_low > 0) begin
      uart_rx = 1'b0;
      wait_cycles(tail_low);
    end
    uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [5:0] exp_keys;
    logic       exp_en;
  } vec_t;

  vec_t tbl[8];

  int v0, f0, v1, v5, r0, r_other;

  initial begin
    // data, stop, valid, rx_data after, keys after, sg90_en after
    tbl[0] = '{8'h58, 1'b1, 1'b1, 8'h58, 6'b000000, 1'b0};  // 'X' disables
    tbl[1] = '{8'h32, 1'b1, 1'b1, 8'h32, 6'b000000, 1'b0};  // '2' ignored while disabled
    tbl[2] = '{8'h45, 1'b1, 1'b1, 8'h45, 6'b000000, 1'b1};  // 'E' enables
    tbl[3] = '{8'h32, 1'b1, 1'b1, 8'h32, 6'b000010, 1'b1};  // '2' moves
    tbl[4] = '{8'h41, 1'b1, 1'b1, 8'h41, 6'b000010, 1'b1};  // 'A' no effect, hold runs on
    tbl[5] = '{8'h36, 1'b1, 1'b1, 8'h36, 6'b100000, 1'b1};  // '6'
    tbl[6] = '{8'h53, 1'b1, 1'b1, 8'h53, 6'b000000, 1'b1};  // 'S' stops
    tbl[7] = '{8'h31, 1'b0, 1'b0, 8'h53, 6'b000000, 1'b1};  // bad stop bit

    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    wait_cycles(5);
    check("reset keys", 32'(keys), 32'h0);
    check("reset sg90_en", 32'(sg90_en), 32'h1);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    sys_rst_n = 1'b1;
    wait_cycles(10);

    // '3' once: key3 high exactly HOLD cycles, starting the cycle after rx_valid
    send_frame(8'h33, 1'b1, 0);
    wait_cycles(2);
    check("t1 valid count", 32'(valid_cnt), 32'd1);
    check("t1 rx_data", 32'(rx_data), 32'h33);
    check("t1 key3 rise latency", 32'(rise_cyc[2] - valid_cyc), 32'd1);
    wait_cycles(HOLD + 50);
    check("t1 key3 high cycles", 32'(last_run[2]), 32'(HOLD));
    r_other = rise_cnt[0] + rise_cnt[1] + rise_cnt[3] + rise_cnt[4] + rise_cnt[5];
    check("t1 other keys", 32'(r_other), 32'd0);

    // '1' repeated with a short idle gap: one continuous level
    r0 = rise_cnt[0];
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h31, 1'b1, 0);
      if (k == 0) v1 = valid_cyc;
      wait_cycles(20);
    end
    v5 = valid_cyc;
    wait_cycles(HOLD + 50);
    check("t2 key1 single run", 32'(rise_cnt[0] - r0), 32'd1);
    check("t2 key1 run length", 32'(last_run[0]), 32'(v5 - v1 + HOLD));
    check("t2 key1 dropped", 32'(key1), 32'h0);

    // '5' then '6' back-to-back, then 'S'
    send_frame(8'h35, 1'b1, 0);
    send_frame(8'h36, 1'b1, 0);
    wait_cycles(2);
    check("t3 rx_data", 32'(rx_data), 32'h36);
    check("t3 key5->key6 same cycle", 32'(fall_cyc[4]), 32'(rise_cyc[5]));
    check("t3 key6 high", 32'(keys), 32'b100000);
    send_frame(8'h53, 1'b1, 0);
    wait_cycles(2);
    check("t3 S keys", 32'(keys_snap), 32'h0);
    check("t3 never two keys", 32'(multi_hot), 32'd0);
    wait_cycles(4);

    // Table-driven command vectors
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(tbl[i].data, tbl[i].stop, 0);
      wait_cycles(2);
      check($sformatf("vec%0d rx_valid", i), 32'(valid_cnt - v0), 32'(tbl[i].exp_valid));
      check($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - f0), 32'(!tbl[i].exp_valid));
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(tbl[i].exp_data));
      check($sformatf("vec%0d keys", i),
            32'(tbl[i].exp_valid ? keys_snap : keys), 32'(tbl[i].exp_keys));
      check($sformatf("vec%0d sg90_en", i),
            32'(tbl[i].exp_valid ? en_snap : sg90_en), 32'(tbl[i].exp_en));
      wait_cycles(4);
    end

    // Short low glitch on the idle line: rejected at the start-bit sample
    v0 = valid_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    wait_cycles(4);
    uart_rx = 1'b1;
    wait_cycles(40);
    check("glitch rx_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("glitch rx_data", 32'(rx_data), 32'h53);
    check("glitch keys", 32'(keys), 32'h0);

    // Frame error followed by a break: one error pulse, no restart until high
    send_frame(8'h31, 1'b0, 80);
    wait_cycles(40);
    check("break frame_err", 32'(ferr_cnt - f0), 32'd1);
    check("break rx_valid", 32'(valid_cnt - v0), 32'd0);
    check("break key1", 32'(key1), 32'h0);

    // Reset mid-DATA while key4 is held
    send_frame(8'h34, 1'b1, 0);
    wait_cycles(2);
    check("t6 key4 held", 32'(keys), 32'b001000);
    uart_rx = 1'b0;
    wait_cycles(CPB);
    uart_rx = 1'b1;
    wait_cycles(CPB + 10);
    #3 sys_rst_n = 1'b0;
    #1;
    check("t6 async keys", 32'(keys), 32'h0);
    check("t6 async rx_data", 32'(rx_data), 32'h00);
    check("t6 async sg90_en", 32'(sg90_en), 32'h1);
    check("t6 async rx_valid", 32'(rx_valid), 32'h0);
    check("t6 async frame_err", 32'(frame_err), 32'h0);
    uart_rx = 1'b0;
    wait_cycles(5);
    sys_rst_n = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    wait_cycles(CPB * 12);
    check("t6 low after reset valid", 32'(valid_cnt - v0), 32'd0);
    check("t6 low after reset ferr", 32'(ferr_cnt - f0), 32'd0);
    uart_rx = 1'b1;
    wait_cycles(5);
    send_frame(8'h34, 1'b1, 0);
    wait_cycles(2);
    check("t6 clean rx_data", 32'(rx_data), 32'h34);
    check("t6 clean valid", 32'(valid_cnt - v0), 32'd1);
    check("t6 key4 rise latency", 32'(rise_cyc[3] - valid_cyc), 32'd1);
    check("t6 key4 high", 32'(keys), 32'b001000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
